// File: rtl/sobel_frame_ctrl_if.sv
// Host/line-memory/array bundle for the Sobel row sequencer.
// SOBEL_CTRL_PERF_EN adds the frame_cycles / frame_count counters.
interface sobel_frame_ctrl_if #(
    parameter int ROW_W = 8
);
    logic             start;
    logic             abort;
    logic             rd_en;
    logic [ROW_W-1:0] rd_row;
    logic             out_valid;
    logic [ROW_W-1:0] out_row;
    logic             busy;
    logic             done;
    logic             aborted;
`ifdef SOBEL_CTRL_PERF_EN
    logic [15:0]      frame_cycles;
    logic [15:0]      frame_count;

    modport master (
        input  start, abort,
        output rd_en, rd_row, out_valid, out_row,
        output busy, done, aborted,
        output frame_cycles, frame_count
    );

    modport slave (
        output start, abort,
        input  rd_en, rd_row, out_valid, out_row,
        input  busy, done, aborted,
        input  frame_cycles, frame_count
    );
`else
    modport master (
        input  start, abort,
        output rd_en, rd_row, out_valid, out_row,
        output busy, done, aborted
    );

    modport slave (
        output start, abort,
        input  rd_en, rd_row, out_valid, out_row,
        input  busy, done, aborted
    );
`endif
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Row sequencer for the column-parallel Sobel array: reads rows, tags outputs.
// Optional SOBEL_CTRL_PERF_EN adds busy-cycle and frame counters.
module sobel_frame_ctrl #(
    parameter int IMG_H    = 64,
    parameter int ROW_W    = 8,
    parameter int PIPE_LAT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    sobel_frame_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] ONE_ROW  = ROW_W'(1);
    localparam logic [ROW_W-1:0] TWO_ROW  = ROW_W'(2);
    localparam logic [3:0]       LAT      = 4'(PIPE_LAT);

    state_t           state_q, state_d;
    logic [ROW_W-1:0] cnt_q, cnt_d;
    logic [3:0]       dcnt_q, dcnt_d;
    logic             rd_en_q, rd_en_d;
    logic [ROW_W-1:0] rd_row_q, rd_row_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             flush;
    logic             accept;

    logic [PIPE_LAT-1:0] vld_q;
    logic [ROW_W-1:0]    row_q [PIPE_LAT];
    logic                tag_new;
    logic [ROW_W-1:0]    row_new;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus next values of the registered outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dcnt_d    = dcnt_q;
        rd_en_d   = 1'b0;
        rd_row_d  = rd_row_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        flush     = 1'b0;
        accept    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_FETCH;
                    cnt_d    = '0;
                    rd_en_d  = 1'b1;
                    rd_row_d = '0;
                    busy_d   = 1'b1;
                    accept   = 1'b1;
                end
            end
            S_FETCH: begin
                if (bus.abort) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                    flush     = 1'b1;
                end else if (cnt_q == LAST_ROW) begin
                    state_d = S_DRAIN;
                    dcnt_d  = LAT;
                    busy_d  = 1'b1;
                end else begin
                    cnt_d    = cnt_q + ONE_ROW;
                    rd_en_d  = 1'b1;
                    rd_row_d = cnt_q + ONE_ROW;
                    busy_d   = 1'b1;
                end
            end
            S_DRAIN: begin
                if (bus.abort) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                    flush     = 1'b1;
                end else begin
                    dcnt_d = dcnt_q - 4'd1;
                    if (dcnt_q == 4'd1) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        busy_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered read strobe, counters and host status
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            dcnt_q    <= '0;
            rd_en_q   <= 1'b0;
            rd_row_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dcnt_q    <= dcnt_d;
            rd_en_q   <= rd_en_d;
            rd_row_q  <= rd_row_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    // Row k as bottom neighbour completes centre row k-1; rows 0/1 as bottom are border
    assign tag_new = rd_en_q && (rd_row_q >= TWO_ROW);
    assign row_new = rd_row_q - ONE_ROW;

    // Latency-matching pipe; rows only advance with a tag so out_row holds
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                row_q[i] <= '0;
            end
        end else if (flush) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= tag_new;
            if (tag_new) begin
                row_q[0] <= row_new;
            end
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    row_q[i] <= row_q[i-1];
                end
            end
        end
    end

    assign bus.rd_en     = rd_en_q;
    assign bus.rd_row    = rd_row_q;
    assign bus.out_valid = vld_q[PIPE_LAT-1];
    assign bus.out_row   = row_q[PIPE_LAT-1];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;

`ifdef SOBEL_CTRL_PERF_EN
    logic [15:0] fcyc_q;
    logic [15:0] fcnt_q;

    // Busy-cycle count of the latest frame and completed-frame count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fcyc_q <= '0;
            fcnt_q <= '0;
        end else begin
            if (accept) begin
                fcyc_q <= '0;
            end else if (busy_q) begin
                fcyc_q <= fcyc_q + 16'd1;
            end
            if (done_q) begin
                fcnt_q <= fcnt_q + 16'd1;
            end
        end
    end

    assign bus.frame_cycles = fcyc_q;
    assign bus.frame_count  = fcnt_q;
`endif

endmodule
